cmn_list_free_alloc: RTL and testbench

//  Multi-lane free-entry allocator for list/queue structures (ROB, LSQ, tag pools).
//  - Holds the registered free bitmap (1 = free).
//  - Feeds the bitmap to a reversed leading-one finder.
//  - Grants up to REQ_NUM in-order allocations per cycle.
//  - Frees entries on a release bitmask or a global flush.
//  - Sits between dispatch/rename (requesters) and the entry storage array.

---
 rtl/cmn_list_free_alloc_pkg.sv | 17 +
 rtl/cmn_list_free_alloc_if.sv | 32 +++
 rtl/cmn_list_free_alloc_chk.sv | 49 ++++
 rtl/cmn_list_free_alloc_lead_one_rev.sv | 40 ++++
 rtl/cmn_list_free_alloc.sv | 120 ++++++++++++
 tb/tb_cmn_list_free_alloc.sv | 204 ++++++++++++++++++++
 6 files changed

// File: rtl/cmn_list_free_alloc_pkg.sv
// Shared constants and width helpers for the list free-entry allocator.
package cmn_list_free_alloc_pkg;

  localparam int DEF_ENTRY_NUM = 16;
  localparam int DEF_REQ_NUM   = 4;

  // Binary index width; a single entry still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Free-count width: must be able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cmn_list_free_alloc_if.sv
// Allocation / release bundle between requesters and the allocator.
interface cmn_list_free_alloc_if
  import cmn_list_free_alloc_pkg::*;
#(
  parameter int ENTRY_NUM = DEF_ENTRY_NUM,
  parameter int REQ_NUM   = DEF_REQ_NUM
);

  localparam int AWIDTH = idx_width(ENTRY_NUM);
  localparam int CWIDTH = cnt_width(ENTRY_NUM);

  logic [REQ_NUM-1:0]                v_alloc_req;
  logic [REQ_NUM-1:0]                v_alloc_gnt;
  logic [REQ_NUM-1:0][ENTRY_NUM-1:0] v_alloc_idx_oh;
  logic [REQ_NUM-1:0][AWIDTH-1:0]    v_alloc_idx_bin;
  logic [ENTRY_NUM-1:0]              v_dealloc_vld;
  logic                              flush;
  logic [CWIDTH-1:0]                 free_cnt;
  logic                              all_free;
  logic                              none_free;

  modport master (
    output v_alloc_req, v_dealloc_vld, flush,
    input  v_alloc_gnt, v_alloc_idx_oh, v_alloc_idx_bin, free_cnt, all_free, none_free
  );

  modport slave (
    input  v_alloc_req, v_dealloc_vld, flush,
    output v_alloc_gnt, v_alloc_idx_oh, v_alloc_idx_bin, free_cnt, all_free, none_free
  );

endinterface

// File: rtl/cmn_list_free_alloc_chk.sv
// Protocol and consistency checks for the free-entry allocator.
module cmn_list_free_alloc_chk
  import cmn_list_free_alloc_pkg::*;
#(
  parameter int ENTRY_NUM = DEF_ENTRY_NUM,
  parameter int REQ_NUM   = DEF_REQ_NUM,
  localparam int CWIDTH   = cnt_width(ENTRY_NUM)
) (
  input logic                              clk,
  input logic                              rst_n,
  input logic [REQ_NUM-1:0]                i_req,
  input logic [ENTRY_NUM-1:0]              i_dealloc,
  input logic [ENTRY_NUM-1:0]              i_free_q,
  input logic [REQ_NUM-1:0][ENTRY_NUM-1:0] i_oh,
  input logic [CWIDTH-1:0]                 i_free_cnt
);

  logic [REQ_NUM-1:0] w_req_p1;
  logic               w_overlap;
  logic [ENTRY_NUM-1:0] w_seen;

  // Detect any entry granted to more than one lane.
  always_comb begin
    w_req_p1  = i_req + REQ_NUM'(1);
    w_overlap = 1'b0;
    w_seen    = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      w_overlap = w_overlap | (|(w_seen & i_oh[i]));
      w_seen    = w_seen | i_oh[i];
    end
  end

  a_req_prefix : assert property (@(posedge clk) disable iff (!rst_n)
    (w_req_p1 & i_req) == '0)
    else $error("alloc request lanes not prefix-contiguous");

  a_dealloc_alloc : assert property (@(posedge clk) disable iff (!rst_n)
    (i_dealloc & i_free_q) == '0)
    else $error("dealloc of an entry that is already free");

  a_oh_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !w_overlap)
    else $error("one-hot grants overlap across lanes");

  a_cnt_match : assert property (@(posedge clk) disable iff (!rst_n)
    i_free_cnt == CWIDTH'($countones(i_free_q)))
    else $error("free count disagrees with free bitmap");

endmodule

// File: rtl/cmn_list_free_alloc_lead_one_rev.sv
// Reversed leading-one finder: lane l receives the l-th highest set bit of i_vec.
module cmn_list_lead_one_rev
  import cmn_list_free_alloc_pkg::*;
#(
  parameter int ENTRY_NUM = DEF_ENTRY_NUM,
  parameter int REQ_NUM   = DEF_REQ_NUM,
  localparam int AWIDTH   = idx_width(ENTRY_NUM)
) (
  input  logic [ENTRY_NUM-1:0]              i_vec,
  output logic [REQ_NUM-1:0]                o_vld,
  output logic [REQ_NUM-1:0][ENTRY_NUM-1:0] o_oh,
  output logic [REQ_NUM-1:0][AWIDTH-1:0]    o_bin
);

  logic [ENTRY_NUM-1:0] w_rem;
  logic                 w_found;
  logic                 w_pick;

  // Peel off the highest remaining set bit once per lane.
  always_comb begin
    w_rem   = i_vec;
    w_found = 1'b0;
    w_pick  = 1'b0;
    o_vld   = '0;
    o_oh    = '0;
    o_bin   = '0;
    for (int l = 0; l < REQ_NUM; l++) begin
      w_found = 1'b0;
      for (int e = ENTRY_NUM - 1; e >= 0; e--) begin
        w_pick      = ~w_found & w_rem[e];
        o_oh[l][e]  = w_pick;
        o_bin[l]    = o_bin[l] | (w_pick ? AWIDTH'(e) : {AWIDTH{1'b0}});
        w_found     = w_found | w_pick;
      end
      o_vld[l] = w_found;
      w_rem    = w_rem & ~o_oh[l];
    end
  end

endmodule

// File: rtl/cmn_list_free_alloc.sv
// Multi-lane free-entry allocator: free bitmap, in-order grant chain, release and flush.
module cmn_list_free_alloc
  import cmn_list_free_alloc_pkg::*;
#(
  parameter int ENTRY_NUM = DEF_ENTRY_NUM,
  parameter int REQ_NUM   = DEF_REQ_NUM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cmn_list_free_alloc_if.slave   alloc_if
);

  localparam int AWIDTH = idx_width(ENTRY_NUM);
  localparam int CWIDTH = cnt_width(ENTRY_NUM);

  logic [ENTRY_NUM-1:0]              r_free_q;
  logic [CWIDTH-1:0]                 r_free_cnt;
  logic                              r_all_free;
  logic                              r_none_free;

  logic [REQ_NUM-1:0]                w_free_vld;
  logic [REQ_NUM-1:0][ENTRY_NUM-1:0] w_cand_oh;
  logic [REQ_NUM-1:0][AWIDTH-1:0]    w_cand_bin;
  logic [REQ_NUM-1:0]                w_gnt;
  logic                              w_chain;
  logic [REQ_NUM-1:0][ENTRY_NUM-1:0] w_gnt_oh;
  logic [REQ_NUM-1:0][AWIDTH-1:0]    w_gnt_bin;
  logic [ENTRY_NUM-1:0]              w_alloc_mask;
  logic [ENTRY_NUM-1:0]              w_free_n;
  logic [CWIDTH-1:0]                 w_free_cnt_n;

  function automatic logic [CWIDTH-1:0] popcnt(input logic [ENTRY_NUM-1:0] v);
    logic [CWIDTH-1:0] c;
    c = '0;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      c = c + CWIDTH'(v[k]);
    end
    return c;
  endfunction

  cmn_list_lead_one_rev #(
    .ENTRY_NUM (ENTRY_NUM),
    .REQ_NUM   (REQ_NUM)
  ) u_lead_one_rev (
    .i_vec (r_free_q),
    .o_vld (w_free_vld),
    .o_oh  (w_cand_oh),
    .o_bin (w_cand_bin)
  );

  // Grant chain: a lane is granted only if every lower lane was granted.
  always_comb begin
    w_gnt   = '0;
    w_chain = 1'b1;
    for (int i = 0; i < REQ_NUM; i++) begin
      w_gnt[i] = alloc_if.v_alloc_req[i] & w_free_vld[i] & w_chain & ~alloc_if.flush;
      w_chain  = w_gnt[i];
    end
  end

  // Zero the indices of ungranted lanes and collect the entries being taken.
  always_comb begin
    w_gnt_oh     = '0;
    w_gnt_bin    = '0;
    w_alloc_mask = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      w_gnt_oh[i]  = w_gnt[i] ? w_cand_oh[i]  : {ENTRY_NUM{1'b0}};
      w_gnt_bin[i] = w_gnt[i] ? w_cand_bin[i] : {AWIDTH{1'b0}};
      w_alloc_mask = w_alloc_mask | w_gnt_oh[i];
    end
  end

  // Next free bitmap: flush frees everything, else retire grants and add releases.
  always_comb begin
    if (alloc_if.flush) begin
      w_free_n = '1;
    end else begin
      w_free_n = (r_free_q & ~w_alloc_mask) | alloc_if.v_dealloc_vld;
    end
    w_free_cnt_n = popcnt(w_free_n);
  end

  // State and status registers; reset leaves every entry free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free_q    <= '1;
      r_free_cnt  <= CWIDTH'(ENTRY_NUM);
      r_all_free  <= 1'b1;
      r_none_free <= 1'b0;
    end else begin
      r_free_q    <= w_free_n;
      r_free_cnt  <= w_free_cnt_n;
      r_all_free  <= (w_free_cnt_n == CWIDTH'(ENTRY_NUM));
      r_none_free <= (w_free_cnt_n == {CWIDTH{1'b0}});
    end
  end

  assign alloc_if.v_alloc_gnt     = w_gnt;
  assign alloc_if.v_alloc_idx_oh  = w_gnt_oh;
  assign alloc_if.v_alloc_idx_bin = w_gnt_bin;
  assign alloc_if.free_cnt        = r_free_cnt;
  assign alloc_if.all_free        = r_all_free;
  assign alloc_if.none_free       = r_none_free;

`ifndef SYNTHESIS
  cmn_list_free_alloc_chk #(
    .ENTRY_NUM (ENTRY_NUM),
    .REQ_NUM   (REQ_NUM)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (alloc_if.v_alloc_req),
    .i_dealloc  (alloc_if.v_dealloc_vld),
    .i_free_q   (r_free_q),
    .i_oh       (w_gnt_oh),
    .i_free_cnt (r_free_cnt)
  );
`endif

endmodule

// File: tb/tb_cmn_list_free_alloc.sv
// Randomized bench for cmn_list_free_alloc with a free-list reference model.
module tb_cmn_list_free_alloc;

  localparam int EN = 16;
  localparam int RN = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which entries are free, as a plain array.
  bit m_free [EN] = '{default: 1'b1};
  bit m_next [EN];
  int q[$];
  bit [RN-1:0] eg;
  bit chain;
  int cnt;

  cmn_list_free_alloc_if #(.ENTRY_NUM(EN), .REQ_NUM(RN)) bus ();

  cmn_list_free_alloc #(.ENTRY_NUM(EN), .REQ_NUM(RN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alloc_if (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: predict grants from the free list, compare, and form next state.
  always @(negedge clk) begin
    q = {};
    for (int e = EN - 1; e >= 0; e--) begin
      if (m_free[e]) q.push_back(e);
    end
    cnt   = q.size();
    chain = 1'b1;
    eg    = '0;
    for (int i = 0; i < RN; i++) begin
      eg[i] = chain && !bus.flush && bus.v_alloc_req[i] && (i < q.size());
      chain = eg[i];
    end
    chk("gnt", 32'(bus.v_alloc_gnt), 32'(eg));
    for (int i = 0; i < RN; i++) begin
      chk("idx_bin", 32'(bus.v_alloc_idx_bin[i]), eg[i] ? 32'(q[i]) : 32'd0);
      chk("idx_oh", 32'(bus.v_alloc_idx_oh[i]), eg[i] ? (32'd1 << q[i]) : 32'd0);
    end
    chk("free_cnt", 32'(bus.free_cnt), 32'(cnt));
    chk("all_free", 32'(bus.all_free), 32'(cnt == EN));
    chk("none_free", 32'(bus.none_free), 32'(cnt == 0));
    for (int e = 0; e < EN; e++) m_next[e] = m_free[e];
    if (bus.flush) begin
      for (int e = 0; e < EN; e++) m_next[e] = 1'b1;
    end else begin
      for (int i = 0; i < RN; i++) if (eg[i]) m_next[q[i]] = 1'b0;
      for (int e = 0; e < EN; e++) if (bus.v_dealloc_vld[e]) m_next[e] = 1'b1;
    end
  end

  // Model state commit, with asynchronous reset like the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < EN; e++) m_free[e] <= 1'b1;
    end else begin
      for (int e = 0; e < EN; e++) m_free[e] <= m_next[e];
    end
  end

  initial begin
    int n;
    bus.v_alloc_req   = '0;
    bus.v_dealloc_vld = '0;
    bus.flush         = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_cnt", 32'(bus.free_cnt), 32'd16);
    chk("rst_all", 32'(bus.all_free), 32'd1);
    chk("rst_none", 32'(bus.none_free), 32'd0);

    // Four full bursts drain the pool from the top down.
    tick();
    rst_n = 1'b1;
    bus.v_alloc_req = 4'b1111;
    @(negedge clk);
    chk("t1_gnt", 32'(bus.v_alloc_gnt), 32'b1111);
    chk("t1_idx0", 32'(bus.v_alloc_idx_bin[0]), 32'd15);
    chk("t1_idx1", 32'(bus.v_alloc_idx_bin[1]), 32'd14);
    chk("t1_idx2", 32'(bus.v_alloc_idx_bin[2]), 32'd13);
    chk("t1_idx3", 32'(bus.v_alloc_idx_bin[3]), 32'd12);
    tick();
    @(negedge clk);
    chk("t1_cnt", 32'(bus.free_cnt), 32'd12);
    tick();
    tick();
    @(negedge clk);
    chk("t2_idx0", 32'(bus.v_alloc_idx_bin[0]), 32'd3);
    chk("t2_idx3", 32'(bus.v_alloc_idx_bin[3]), 32'd0);
    tick();
    @(negedge clk);
    chk("t2_cnt", 32'(bus.free_cnt), 32'd0);
    chk("t2_none", 32'(bus.none_free), 32'd1);
    chk("t2_gnt", 32'(bus.v_alloc_gnt), 32'd0);

    // Two free entries, four requests: only the two lowest lanes win.
    tick();
    bus.v_alloc_req   = 4'b0000;
    bus.v_dealloc_vld = 16'h0088;
    tick();
    bus.v_dealloc_vld = 16'h0000;
    bus.v_alloc_req   = 4'b1111;
    @(negedge clk);
    chk("t3_gnt", 32'(bus.v_alloc_gnt), 32'b0011);
    chk("t3_idx0", 32'(bus.v_alloc_idx_bin[0]), 32'd7);
    chk("t3_idx1", 32'(bus.v_alloc_idx_bin[1]), 32'd3);
    chk("t3_oh2", 32'(bus.v_alloc_idx_oh[2]), 32'd0);
    tick();
    bus.v_alloc_req = 4'b0000;
    @(negedge clk);
    chk("t3_cnt", 32'(bus.free_cnt), 32'd0);

    // Release is not bypassed into the same-cycle grant.
    tick();
    bus.v_dealloc_vld = 16'h0005;
    bus.v_alloc_req   = 4'b0001;
    @(negedge clk);
    chk("t4_gnt0", 32'(bus.v_alloc_gnt), 32'd0);
    tick();
    bus.v_dealloc_vld = 16'h0000;
    @(negedge clk);
    chk("t4_gnt1", 32'(bus.v_alloc_gnt), 32'b0001);
    chk("t4_idx", 32'(bus.v_alloc_idx_bin[0]), 32'd2);
    chk("t4_cnt2", 32'(bus.free_cnt), 32'd2);
    tick();
    bus.v_alloc_req = 4'b0000;
    @(negedge clk);
    chk("t4_cnt1", 32'(bus.free_cnt), 32'd1);

    // Flush beats allocation and release.
    tick();
    bus.flush         = 1'b1;
    bus.v_alloc_req   = 4'b1111;
    bus.v_dealloc_vld = 16'h0010;
    @(negedge clk);
    chk("t5_gnt", 32'(bus.v_alloc_gnt), 32'd0);
    tick();
    bus.flush         = 1'b0;
    bus.v_alloc_req   = 4'b0000;
    bus.v_dealloc_vld = 16'h0000;
    @(negedge clk);
    chk("t5_cnt", 32'(bus.free_cnt), 32'd16);
    chk("t5_all", 32'(bus.all_free), 32'd1);

    // Random traffic: contiguous requests, releases only of allocated entries.
    for (int c = 0; c < 800; c++) begin
      tick();
      n = $urandom_range(0, RN);
      bus.v_alloc_req = RN'((1 << n) - 1);
      bus.flush       = ($urandom_range(0, 39) == 0);
      for (int e = 0; e < EN; e++) begin
        bus.v_dealloc_vld[e] = !m_free[e] && ($urandom_range(0, 4) == 0);
      end
    end

    // Asynchronous reset in the middle of a burst.
    tick();
    bus.flush         = 1'b0;
    bus.v_dealloc_vld = '0;
    bus.v_alloc_req   = 4'b1111;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_cnt", 32'(bus.free_cnt), 32'd16);
    chk("t6_all", 32'(bus.all_free), 32'd1);
    chk("t6_none", 32'(bus.none_free), 32'd0);
    chk("t6_idx_rst", 32'(bus.v_alloc_idx_bin[0]), 32'd15);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_gnt", 32'(bus.v_alloc_gnt), 32'b1111);
    chk("t6_idx", 32'(bus.v_alloc_idx_bin[0]), 32'd15);
    tick();
    bus.v_alloc_req = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
